// File: rtl/parking_pkg.sv
// Shared types and default constants for the parking entry keypad and controller.
package parking_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StCollect = 3'd1,
        StPresent = 3'd2,
        StDone    = 3'd3,
        StLockout = 3'd4
    } park_state_e;

    localparam int unsigned PARK_PASS_W      = 4;
    localparam int unsigned PARK_TIMEOUT     = 1000;
    localparam int unsigned PARK_GATE_WAIT   = 8;
    localparam int unsigned PARK_MAX_TRIES   = 3;
    localparam int unsigned PARK_LOCK_CYCLES = 5000;

    // System code; must be non-zero because pass reads all-zeros outside PRESENT.
    localparam logic [3:0] PARK_PASS_DEFAULT = 4'b1001;

    function automatic int unsigned park_max3(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/parking_cycle_timer.sv
// Loadable down-counter; expire is high while the count reads 1.
module parking_cycle_timer #(
    parameter int unsigned WIDTH = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expire
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign expire = (count_q == WIDTH'(1));

endmodule

// File: rtl/parking_pass_entry.sv
// Keypad front end: collects a serial password, presents it to the entry controller,
// counts failed attempts and enforces a timed lockout.
module parking_pass_entry
    import parking_pkg::*;
#(
    parameter int unsigned PASS_W      = PARK_PASS_W,
    parameter int unsigned TIMEOUT     = PARK_TIMEOUT,
    parameter int unsigned GATE_WAIT   = PARK_GATE_WAIT,
    parameter int unsigned MAX_TRIES   = PARK_MAX_TRIES,
    parameter int unsigned LOCK_CYCLES = PARK_LOCK_CYCLES,
    localparam int unsigned DW = $clog2(PASS_W + 1),
    localparam int unsigned TRW = $clog2(MAX_TRIES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sensor,
    input  logic              key_stb,
    input  logic              key_bit,
    input  logic              key_clr,
    input  logic              gate_open,
    output logic [PASS_W-1:0] pass,
    output logic              pass_ready,
    output logic              locked,
    output logic [DW-1:0]     digit_cnt,
    output logic [TRW-1:0]    tries
);

    // Sized to hold the largest load value itself.
    localparam int unsigned TW = $clog2(park_max3(TIMEOUT, GATE_WAIT, LOCK_CYCLES) + 1);

    park_state_e       state_q, state_d;
    logic [PASS_W-1:0] shift_q, shift_d;
    logic [PASS_W-1:0] pass_q, pass_d;
    logic [DW-1:0]     digit_q, digit_d;
    logic [TRW-1:0]    tries_q, tries_d;
    logic              ready_q, locked_q;
    logic              tmr_load, tmr_expire;
    logic [TW-1:0]     tmr_val;

    parking_cycle_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        pass_d   = pass_q;
        digit_d  = digit_q;
        tries_d  = tries_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            StIdle: begin
                if (sensor) begin
                    state_d  = StCollect;
                    shift_d  = '0;
                    digit_d  = '0;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(TIMEOUT);
                end
            end
            StCollect: begin
                if (!sensor) begin
                    state_d = StIdle;
                    shift_d = '0;
                    digit_d = '0;
                end else if (key_clr) begin
                    shift_d  = '0;
                    digit_d  = '0;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(TIMEOUT);
                end else if (key_stb) begin
                    shift_d  = {shift_q[PASS_W-2:0], key_bit};
                    tmr_load = 1'b1;
                    if (digit_q == DW'(PASS_W - 1)) begin
                        state_d = StPresent;
                        pass_d  = shift_d;
                        digit_d = '0;
                        tmr_val = TW'(GATE_WAIT);
                    end else begin
                        digit_d = digit_q + 1'b1;
                        tmr_val = TW'(TIMEOUT);
                    end
                end else if (tmr_expire) begin
                    shift_d  = '0;
                    digit_d  = '0;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(TIMEOUT);
                end
            end
            StPresent: begin
                if (!sensor) begin
                    state_d = StIdle;
                    pass_d  = '0;
                    shift_d = '0;
                end else if (gate_open) begin
                    state_d = StDone;
                    pass_d  = '0;
                    tries_d = '0;
                end else if (tmr_expire) begin
                    pass_d   = '0;
                    shift_d  = '0;
                    tries_d  = (tries_q == TRW'(MAX_TRIES)) ? tries_q : tries_q + 1'b1;
                    tmr_load = 1'b1;
                    if (tries_d == TRW'(MAX_TRIES)) begin
                        state_d = StLockout;
                        tmr_val = TW'(LOCK_CYCLES);
                    end else begin
                        state_d = StCollect;
                        tmr_val = TW'(TIMEOUT);
                    end
                end
            end
            StDone: begin
                if (!sensor) begin
                    state_d = StIdle;
                end
            end
            StLockout: begin
                if (tmr_expire) begin
                    state_d = StIdle;
                    tries_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            shift_q  <= '0;
            pass_q   <= '0;
            digit_q  <= '0;
            tries_q  <= '0;
            ready_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            pass_q   <= pass_d;
            digit_q  <= digit_d;
            tries_q  <= tries_d;
            ready_q  <= (state_d == StPresent);
            locked_q <= (state_d == StLockout);
        end
    end

    assign pass       = pass_q;
    assign pass_ready = ready_q;
    assign locked     = locked_q;
    assign digit_cnt  = digit_q;
    assign tries      = tries_q;

endmodule

// File: doc/parking_pass_entry.md
# parking_pass_entry

Keypad front end for the parking entry controller. It collects a serially keyed password one bit per strobe while a car is at the gate, then presents the assembled code on `pass`. It watches the controller's `gate_open` response and counts failed attempts, entering a timed lockout after too many. It drives the controller's `pass` input and consumes its gate output.

## Interface
- `PASS_W`, 4: password width in bits, which is also the number of key strobes per attempt.
- `TIMEOUT`, 1000: cycles with no strobe in COLLECT before the partial entry is discarded.
- `GATE_WAIT`, 8: cycles in PRESENT to wait for `gate_open` before declaring failure.
- `MAX_TRIES`, 3: consecutive failures that trigger lockout.
- `LOCK_CYCLES`, 5000: lockout duration in cycles.
- `clk`  in  1: clock.
- `reset`  in  1: reset, synchronous, active-low.
- `sensor`  in  1: car present at the entry.
- `key_stb`  in  1: one-cycle key press strobe.
- `key_bit`  in  1: keyed bit, valid with `key_stb`.
- `key_clr`  in  1: clear the current entry.
- `gate_open`  in  1: gate-open output from the entry controller.
- `pass`  out  PASS_W: presented code; all-zeros unless in PRESENT.
- `pass_ready`  out  1: high while in PRESENT.
- `locked`  out  1: high while in LOCKOUT.
- `digit_cnt`  out  $clog2(PASS_W+1): bits keyed so far in the current attempt.
- `tries`  out  $clog2(MAX_TRIES+1): consecutive failed attempts.

## Operation
- States: IDLE, COLLECT, PRESENT, DONE, LOCKOUT.
- Reset (`reset`=0 at a clk edge):
  - state goes to IDLE;
  - all outputs, the shift register and the timer go to 0.
- IDLE:
  - `sensor`=1 moves to COLLECT with the shift register and `digit_cnt` cleared.
  - Keys are ignored.
- COLLECT:
  - Each `key_stb` shifts the register left, with `key_bit` entering at the LSB, so the first key ends up as the MSB.
  - Each strobe increments `digit_cnt` and reloads the timer to `TIMEOUT`.
  - On the `PASS_W`-th strobe: the register is copied to `pass`, `digit_cnt` is cleared, the timer is loaded with `GATE_WAIT`, and the state moves to PRESENT.
  - `key_clr` clears the register and `digit_cnt` and reloads the timer. It has priority over a simultaneous `key_stb`.
  - Timer expiry clears the register and `digit_cnt` and reloads the timer. The state stays COLLECT and `tries` is unchanged.
  - `sensor`=0 moves to IDLE and clears the partial entry. It has priority over all key events.
- PRESENT:
  - `pass` is held and `pass_ready`=1.
  - `gate_open`=1 moves to DONE, clears `tries`, and zeroes `pass`.
  - Timer expiry without `gate_open` is a failure: `tries` increments and `pass` is zeroed. If the new `tries` equals `MAX_TRIES`, the state moves to LOCKOUT with the timer loaded to `LOCK_CYCLES`. Otherwise it moves to COLLECT with the timer loaded to `TIMEOUT`.
  - `sensor`=0 aborts to IDLE with `tries` unchanged. It has priority over both expiry and `gate_open`.
  - Keys are ignored.
- DONE:
  - `sensor`=0 moves to IDLE.
  - Keys are ignored. This prevents re-entry while the car is still on the sensor.
- LOCKOUT:
  - `locked`=1; keys, `key_clr` and `sensor` are ignored.
  - Timer expiry clears `tries` and moves to IDLE.
- `tries` saturates at `MAX_TRIES` and never wraps.
- `pass` is all-zeros outside PRESENT. The system code must therefore be non-zero, and it is fixed at 4'b1001.

## Timing
- All outputs are registered.
- `pass` and `pass_ready` assert in the cycle after the edge that samples the final `key_stb`. The controller's gate output can then rise, at the earliest, one edge later.
- Timer:
  - It is loaded to N and decrements once per cycle.
  - It expires when it reads 1 and the expiry condition holds. The transition takes effect on that edge.
  - A load of N therefore gives exactly N cycles in the state.
- `gate_open` is sampled on every edge in PRESENT, including the expiry edge; `gate_open` wins over expiry on that edge.
- A key strobe that arrives on the same edge as a transition into COLLECT is not captured.
- Reset mid-attempt discards the entry and `tries` on the same edge.

## Structure
- Package `parking_pkg` holds:
  - the state enum, with fixed encodings IDLE=0, COLLECT=1, PRESENT=2, DONE=3, LOCKOUT=4;
  - the default parameter constants;
  - `PARK_PASS_DEFAULT`=4'b1001, which is shared with the entry controller.
- Sub-module `parking_cycle_timer` provides load/value/decrement/expire behaviour:
  - Its width is `$clog2` of the largest of `TIMEOUT`, `GATE_WAIT` and `LOCK_CYCLES`.
  - One instance is shared between the TIMEOUT, GATE_WAIT and LOCK uses, because only one of them is active per state.

## Test plan
Bench parameters: `PASS_W`=4, `TIMEOUT`=16, `GATE_WAIT`=4, `MAX_TRIES`=3, `LOCK_CYCLES`=32.
- Reset while in COLLECT with `digit_cnt`=2 -> the next cycle shows IDLE, `pass`=0, `tries`=0 and all flags 0.
- `sensor`=1, then keys 1,0,0,1, then `gate_open` asserted 2 cycles after `pass_ready` rises -> `pass`=4'b1001 for 2 cycles, then DONE with `pass`=0 and `tries`=0; dropping `sensor` returns the block to IDLE.
- Three wrong entries of 4'b0110 with `gate_open` held at 0 -> each PRESENT lasts exactly 4 cycles and `tries` steps 1, 2, 3. `locked` stays high for 32 cycles and keys pressed during lockout have no effect. The block then returns to IDLE with `tries`=0.
- Enter 2 keys, then wait 16 idle cycles -> `digit_cnt` returns to 0, the state stays COLLECT and `tries` is unchanged. Next, `key_clr` and `key_stb` in the same cycle -> `digit_cnt`=0 and the key is not captured.
- `sensor` falls on the same edge as GATE_WAIT expiry -> the block goes to IDLE and `tries` does not increment.
- In PRESENT, `gate_open` rises on the expiry edge -> the block goes to DONE and `tries` is cleared to 0.
